pc_redirect_unit: RTL and testbench
===================================

# pc_redirect_unit

Program-counter and fetch-redirect stage that sits directly downstream of `branch_control`. It owns the fetch PC, issues instruction-memory requests over a valid/ready handshake, and consumes the `branch` decision and operands from execute to compute the redirect target. On a taken branch or jump it redirects fetch and asserts `flush` for a fixed number of cycles so the decode and execute stages can kill wrong-path instructions.

## Interface
Parameters:
- `XLEN`, 32: datapath and address width.
- `RESET_VEC`, 32'h0000_0000: first fetch address after reset.
- `FLUSH_CYCLES`, 2: number of cycles `flush` stays high per redirect. Range 1–7.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: hazard hold. PC does not advance on a completed fetch.
- `branch` in 1: taken decision from `branch_control`, valid in the current cycle.
- `jalr` in 1: selects a register-relative target.
- `pc_ex` in XLEN: PC of the instruction in execute.
- `rs1_ex` in XLEN: rs1 operand in execute.
- `imm_ex` in XLEN: sign-extended immediate in execute.
- `imem_req` out 1: fetch request valid.
- `imem_addr` out XLEN: fetch address. Equal to `pc`.
- `imem_ready` in 1: memory accepts or returns for the current request.
- `pc` out XLEN: current fetch PC.
- `flush` out 1: kill the IF/ID and ID/EX contents.
- `redirect` out 1: one-cycle pulse when a redirect is accepted.
- `misaligned` out 1: misaligned-target trap pulse. Tied 0 unless `MISALIGN_TRAP_EN` is defined.

## Operation
- States: `RST`, `FETCH`, `WAIT`, `HALT`.
- `RST`:
  - Entered while `rst` is high.
  - Next cycle goes to `FETCH`.
- `FETCH`:
  - `imem_req`=1.
  - If `imem_ready`=1, the transfer completes and the state stays `FETCH`.
  - If `imem_ready`=0, go to `WAIT`.
- `WAIT`:
  - `imem_req`=1.
  - `imem_addr` must hold stable.
  - Go to `FETCH` when `imem_ready`=1.
- Next PC on a completed transfer, in priority order:
  - pending redirect target;
  - otherwise `pc` if `stall`=1;
  - otherwise `pc+4`.
- With no completed transfer, `pc` holds, except for an immediate redirect (see below).
- Target:
  - `jalr`=1: (`rs1_ex`+`imm_ex`) & ~1.
  - Otherwise: `pc_ex`+`imm_ex`.
  - Arithmetic is modulo 2^XLEN; wrap-around is silent.
- Redirect accepted when `branch`=1 and `flush`=0:
  - In `FETCH`: `pc` <= target on the next edge. This overrides `pc+4` and `stall`.
  - In `WAIT`: target is latched into a pending register. `pc` <= pending target when `imem_ready` rises; the outstanding response is killed by `flush`.
  - Flush counter loads `FLUSH_CYCLES`; `flush` = (counter != 0); the counter decrements each cycle.
  - `redirect` pulses for one cycle, the cycle after acceptance.
- `branch` while `flush`=1 is ignored, because it comes from a wrong-path instruction.
- `branch` and `stall` in the same cycle: branch wins.
- Reset mid-`WAIT`:
  - Pending redirect is discarded.
  - `pc`=`RESET_VEC`.
  - `imem_req` drops the next cycle, and the outstanding response is ignored.

## Timing
- Reset values:
  - `pc`=`RESET_VEC`.
  - `imem_req`=0, `flush`=0, `redirect`=0, `misaligned`=0.
  - Flush counter=0, pending=0, state=`RST`.
- First request: cycle 1 after `rst` deasserts.
- Redirect latency:
  - From `FETCH`: target appears on `imem_addr` 1 cycle after `branch` is sampled.
  - From `WAIT`: 1 cycle after `imem_ready`.
- `flush` is high from cycle+1 to cycle+`FLUSH_CYCLES` after acceptance.
- All outputs are registered except `imem_addr`, which is `pc`.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A taken target with bits [1:0] != 0 is not redirected.
  - `misaligned` pulses for 1 cycle.
  - `flush` behaves as for a redirect.
  - The state goes to `HALT` (`imem_req`=0) until `rst`.
- `MISALIGN_TRAP_EN` undefined:
  - Target bits [1:0] are forced to 0.
  - `misaligned` is constant 0.
  - `HALT` is unreachable.

## Structure
- Shared `defines.v` holds:
  - state encodings;
  - the `JALR`/`BRANCH` opcode constants;
  - the flush-counter width.
- Sub-module `branch_target_gen`: combinational target adder, the jalr mask, and the alignment check.

## Test plan
- Reset release with `imem_ready`=1 constant → `imem_addr` = 0x0, 0x4, 0x8 on cycles 1–3.
- `branch`=1, `pc_ex`=0x100, `imm_ex`=0xFFFF_FFF0, with `imem_ready`=1 → next `imem_addr`=0xF0, `redirect` pulses once, `flush` is high for exactly 2 cycles.
- `branch` during `WAIT` (ready low for 3 cycles), target 0x200 → `imem_addr` stays stable until ready, then 0x200.
- `jalr`=1, `rs1_ex`=0x1001, `imm_ex`=2 → target 0x1002. With `MISALIGN_TRAP_EN`: `misaligned` pulses and `imem_req`=0 thereafter. Without it: fetch 0x1000.
- A second `branch` one cycle after the first, while `flush`=1 → it is ignored and `pc` follows the first target.
- `stall`=1 and `branch`=1 in the same cycle → redirect taken. `stall` alone → `pc` held.

Source files
------------

// File: rtl/pc_redirect_unit_pkg.sv
// Shared constants for pc_redirect_unit: FSM encodings, opcode constants, flush-counter sizing.
package pc_redirect_unit_pkg;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam int unsigned FLUSH_CNT_W = 3;

  // Reload value for the flush counter, kept inside the 1..7 range the counter can hold.
  function automatic logic [FLUSH_CNT_W-1:0] flush_load(input int unsigned n);
    if (n == 0) return FLUSH_CNT_W'(1);
    if (n > 7) return '1;
    return FLUSH_CNT_W'(n);
  endfunction

endpackage

// File: rtl/pc_redirect_unit_branch_target_gen.sv
// Combinational redirect-target adder with jalr bit-0 mask and word-alignment check.
// MISALIGN_TRAP_EN: when defined the raw target is passed through; otherwise bits [1:0] are cleared.
module branch_target_gen
  import pc_redirect_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic [XLEN-1:0] imm_ex,
  output logic [XLEN-1:0] target_c,
  output logic            misaligned_c
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum_raw;

  always_comb begin
    base    = jalr ? rs1_ex : pc_ex;
    sum_raw = base + imm_ex;
    if (jalr) sum_raw = sum_raw & ~XLEN'(1);
    misaligned_c = (sum_raw[1:0] != 2'b00);
`ifdef MISALIGN_TRAP_EN
    target_c = sum_raw;
`else
    target_c = {sum_raw[XLEN-1:2], 2'b00};
`endif
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC owner: issues imem requests, applies branch/jump redirects and drives the flush window.
// MISALIGN_TRAP_EN: when defined, a misaligned taken target traps to HALT instead of redirecting.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter int unsigned    XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VEC   = 32'h0000_0000,
  parameter int unsigned    FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch,
  input  logic            jalr,
  input  logic [XLEN-1:0] pc_ex,
  input  logic [XLEN-1:0] rs1_ex,
  input  logic [XLEN-1:0] imm_ex,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc,
  output logic            flush,
  output logic            redirect,
  output logic            misaligned
);

  logic [1:0]             state, state_nxt;
  logic [XLEN-1:0]        pc_nxt;
  logic                   pend_vld, pend_vld_nxt;
  logic [XLEN-1:0]        pend_tgt, pend_tgt_nxt;
  logic [FLUSH_CNT_W-1:0] fcnt, fcnt_nxt;
  logic                   req_nxt, flush_nxt, redirect_nxt, misaligned_nxt;

  logic [XLEN-1:0]        target;
  logic                   tgt_misaligned;
  logic                   trap;
  logic                   active, take, xfer;

  branch_target_gen #(.XLEN(XLEN)) u_tgt (
    .jalr         (jalr),
    .pc_ex        (pc_ex),
    .rs1_ex       (rs1_ex),
    .imm_ex       (imm_ex),
    .target_c     (target),
    .misaligned_c (tgt_misaligned)
  );

`ifdef MISALIGN_TRAP_EN
  assign trap = tgt_misaligned;
`else
  logic unused_misaligned;
  assign unused_misaligned = tgt_misaligned;
  assign trap = 1'b0;
`endif

  assign imem_addr = pc;

  // A request is outstanding in FETCH and WAIT; branches during the flush window are wrong-path.
  assign active = (state == ST_FETCH) || (state == ST_WAIT);
  assign take   = active && branch && !flush;
  assign xfer   = active && imem_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST;
      pc         <= RESET_VEC;
      pend_vld   <= 1'b0;
      pend_tgt   <= '0;
      fcnt       <= '0;
      imem_req   <= 1'b0;
      flush      <= 1'b0;
      redirect   <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      pend_vld   <= pend_vld_nxt;
      pend_tgt   <= pend_tgt_nxt;
      fcnt       <= fcnt_nxt;
      imem_req   <= req_nxt;
      flush      <= flush_nxt;
      redirect   <= redirect_nxt;
      misaligned <= misaligned_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    pend_vld_nxt   = pend_vld;
    pend_tgt_nxt   = pend_tgt;
    fcnt_nxt       = (fcnt != '0) ? fcnt - FLUSH_CNT_W'(1) : '0;
    redirect_nxt   = 1'b0;
    misaligned_nxt = 1'b0;

    case (state)
      ST_RST:   state_nxt = ST_FETCH;
      ST_FETCH: if (!imem_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_ready) state_nxt = ST_FETCH;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RST;
    endcase

    // Completed transfer: pending redirect, then stall hold, then sequential.
    if (xfer) begin
      pend_vld_nxt = 1'b0;
      if (pend_vld)   pc_nxt = pend_tgt;
      else if (!stall) pc_nxt = pc + XLEN'(4);
    end

    if (take) begin
      fcnt_nxt = flush_load(FLUSH_CYCLES);
      if (trap) begin
        misaligned_nxt = 1'b1;
        pend_vld_nxt   = 1'b0;
        state_nxt      = ST_HALT;
      end else begin
        redirect_nxt = 1'b1;
        // In WAIT the address must hold until the response; park the target until then.
        if ((state == ST_FETCH) || imem_ready) begin
          pc_nxt       = target;
          pend_vld_nxt = 1'b0;
        end else begin
          pend_vld_nxt = 1'b1;
          pend_tgt_nxt = target;
        end
      end
    end

    req_nxt   = (state_nxt == ST_FETCH) || (state_nxt == ST_WAIT);
    flush_nxt = (fcnt_nxt != '0);
  end

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Self-checking bench for pc_redirect_unit (default build): cycle model plus directed literal checks.
module tb_pc_redirect_unit;

  localparam int unsigned FLUSH = 2;
  localparam logic [31:0] RVEC  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, branch, jalr, imem_ready;
  logic [31:0] pc_ex, rs1_ex, imm_ex;
  logic        imem_req, flush, redirect, misaligned;
  logic [31:0] imem_addr, pc;

  int n_checks = 0;
  int n_err    = 0;

  // Model state: fetch PC, request-outstanding flag, waiting flag, flush cycles left, parked target.
  logic [31:0] m_pc = RVEC;
  bit          m_req = 0;
  bit          m_wait = 0;
  int          m_flush = 0;
  bit          m_pv = 0;
  logic [31:0] m_pend = '0;
  bit          m_red = 0;

  always #5 clk = ~clk;

  pc_redirect_unit #(.XLEN(32), .RESET_VEC(RVEC), .FLUSH_CYCLES(FLUSH)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .branch     (branch),
    .jalr       (jalr),
    .pc_ex      (pc_ex),
    .rs1_ex     (rs1_ex),
    .imm_ex     (imm_ex),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .pc         (pc),
    .flush      (flush),
    .redirect   (redirect),
    .misaligned (misaligned)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one edge from the inputs the DUT just sampled.
  task automatic model_step();
    logic [31:0] tgt, nxt;
    bit take, done;
    if (rst) begin
      m_pc = RVEC; m_req = 0; m_wait = 0; m_flush = 0; m_pv = 0; m_red = 0;
    end else begin
      tgt  = jalr ? ((rs1_ex + imm_ex) & 32'hFFFF_FFFE) : (pc_ex + imm_ex);
      tgt  = tgt & 32'hFFFF_FFFC;
      take = m_req && branch && (m_flush == 0);
      done = m_req && imem_ready;
      nxt  = m_pc;
      if (done) begin
        nxt  = m_pv ? m_pend : (stall ? m_pc : m_pc + 32'd4);
        m_pv = 0;
      end
      if (m_flush > 0) m_flush--;
      m_red = take;
      if (take) begin
        m_flush = FLUSH;
        if (!m_wait || imem_ready) begin nxt = tgt; m_pv = 0; end
        else begin m_pend = tgt; m_pv = 1; end
      end
      m_wait = m_req && !imem_ready;
      m_pc   = nxt;
      m_req  = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("model_req",   32'(imem_req),   32'(m_req));
    check("model_addr",  imem_addr,       m_pc);
    check("model_pc",    pc,              m_pc);
    check("model_flush", 32'(flush),      32'(m_flush != 0));
    check("model_redir", 32'(redirect),   32'(m_red));
    check("model_mis",   32'(misaligned), 32'd0);
  endtask

  task automatic set_br(input logic b, input logic j, input logic [31:0] pe,
                        input logic [31:0] r1, input logic [31:0] im);
    branch = b; jalr = j; pc_ex = pe; rs1_ex = r1; imm_ex = im;
  endtask

  int fl_cnt, rd_cnt;

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b1;
    set_br(1'b0, 1'b0, '0, '0, '0);
    repeat (3) tick();
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_pc",  pc, 32'h0);
    check("rst_flush", 32'(flush), 32'd0);

    // Reset release: sequential fetch 0,4,8
    rst = 1'b0;
    tick(); check("seq_c1", imem_addr, 32'h0); check("seq_req", 32'(imem_req), 32'd1);
    tick(); check("seq_c2", imem_addr, 32'h4);
    tick(); check("seq_c3", imem_addr, 32'h8);

    // Taken branch with negative offset from FETCH
    set_br(1'b1, 1'b0, 32'h100, '0, 32'hFFFF_FFF0);
    tick();
    check("br_addr", imem_addr, 32'hF0);
    set_br(1'b0, 1'b0, '0, '0, '0);
    fl_cnt = int'(flush); rd_cnt = int'(redirect);
    for (int i = 0; i < 3; i++) begin
      tick();
      fl_cnt += int'(flush); rd_cnt += int'(redirect);
    end
    check("br_flush_len", 32'(fl_cnt), 32'd2);
    check("br_redir_cnt", 32'(rd_cnt), 32'd1);
    check("br_seq", pc, 32'hFC);

    // Branch during WAIT: address holds, then jumps after ready
    imem_ready = 1'b0;
    tick(); check("wait_hold0", imem_addr, 32'hFC);
    set_br(1'b1, 1'b0, 32'h200, '0, 32'h0);
    tick(); check("wait_hold1", imem_addr, 32'hFC);
    set_br(1'b0, 1'b0, '0, '0, '0);
    tick(); check("wait_hold2", imem_addr, 32'hFC);
    imem_ready = 1'b1;
    tick(); check("wait_tgt", imem_addr, 32'h200);
    tick(); check("wait_seq", imem_addr, 32'h204);
    tick();

    // jalr with misaligned sum is aligned down in this build
    set_br(1'b1, 1'b1, '0, 32'h1001, 32'h2);
    tick(); check("jalr_tgt", imem_addr, 32'h1000); check("jalr_mis", 32'(misaligned), 32'd0);
    set_br(1'b0, 1'b0, '0, '0, '0);
    repeat (2) tick();

    // Second branch inside flush window is ignored
    set_br(1'b1, 1'b0, 32'h300, '0, 32'h0);
    tick(); check("dbl_first", pc, 32'h300);
    set_br(1'b1, 1'b0, 32'h400, '0, 32'h0);
    tick(); check("dbl_ignored", pc, 32'h304);
    set_br(1'b0, 1'b0, '0, '0, '0);
    repeat (2) tick();
    check("dbl_follow", pc, 32'h30C);

    // Stall with branch: branch wins; stall alone holds
    stall = 1'b1;
    set_br(1'b1, 1'b0, 32'h500, '0, 32'h10);
    tick(); check("stall_br", pc, 32'h510);
    set_br(1'b0, 1'b0, '0, '0, '0);
    tick(); check("stall_hold1", pc, 32'h510);
    tick(); check("stall_hold2", pc, 32'h510);
    stall = 1'b0;
    tick(); check("stall_rel", pc, 32'h514);

    // Reset in WAIT with a parked target: target discarded
    imem_ready = 1'b0;
    tick();
    set_br(1'b1, 1'b0, 32'h600, '0, 32'h0);
    tick();
    set_br(1'b0, 1'b0, '0, '0, '0);
    rst = 1'b1;
    tick(); check("rstw_req", 32'(imem_req), 32'd0); check("rstw_pc", pc, 32'h0);
    rst = 1'b0; imem_ready = 1'b1;
    tick(); check("rstw_c1", imem_addr, 32'h0);
    tick(); check("rstw_c2", imem_addr, 32'h4);

    // Wrap-around target
    set_br(1'b1, 1'b0, 32'hFFFF_FFFC, '0, 32'h8);
    tick(); check("wrap_tgt", pc, 32'h4);
    set_br(1'b0, 1'b0, '0, '0, '0);
    repeat (2) tick();

    // Branch in FETCH while ready is low: immediate redirect, then wait on the new address
    imem_ready = 1'b0;
    set_br(1'b1, 1'b0, 32'h700, '0, 32'h0);
    tick(); check("fwait_tgt", imem_addr, 32'h700);
    set_br(1'b0, 1'b0, '0, '0, '0);
    tick(); check("fwait_hold", imem_addr, 32'h700);
    imem_ready = 1'b1;
    tick(); check("fwait_seq", imem_addr, 32'h704);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
